wb_arbiter: RTL and testbench

Writeback arbiter directly upstream of the general-purpose register file write port. Collects results from four functional-unit sources (ALU, MUL, DIV, LSU) through per-source valid/ready queues. Grants one write per cycle round-robin and drives a single registered write (we/waddr/wdata) into the register file. Also exports a pending-write bitmap used by issue logic for WAW/RAW interlocks.

---
 rtl/wb_arbiter.sv | 100 ++++++++++
 tb/tb_wb_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter from per-source FIFOs into one registered register-file write port.
module wb_arbiter #(
  parameter int NSRC = 4,
  parameter int DEPTH = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSRC-1:0]          src_valid_i,
  output logic [NSRC-1:0]          src_ready_o,
  input  logic [NSRC*ADDR_W-1:0]   src_waddr_i,
  input  logic [NSRC*DATA_W-1:0]   src_wdata_i,
  output logic                     we_o,
  output logic [ADDR_W-1:0]        waddr_o,
  output logic [DATA_W-1:0]        wdata_o,
  output logic [2**ADDR_W-1:0]     pending_o,
  output logic                     idle_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = NSRC > 1 ? $clog2(NSRC) : 1;
  localparam int NREG = 2**ADDR_W;
  logic [NSRC-1:0] ne;
  logic [ADDR_W-1:0] hd_addr [NSRC];
  logic [DATA_W-1:0] hd_data [NSRC];
  logic [NREG-1:0] pend_src [NSRC];
  logic [GW-1:0] last_grant, gnt, cand;
  logic gnt_v;
  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [ADDR_W-1:0] qa [DEPTH];
    logic [DATA_W-1:0] qd [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] cnt;
    logic [NREG-1:0] pend;
    logic push, pop;
    assign src_ready_o[k] = (cnt < CW'(DEPTH)) && !rst;
    // x0 writes complete the handshake but are dropped here
    assign push = src_valid_i[k] && src_ready_o[k] && (src_waddr_i[k*ADDR_W +: ADDR_W] != '0);
    assign pop = gnt_v && (gnt == GW'(k));
    assign ne[k] = cnt != '0;
    assign hd_addr[k] = qa[head];
    assign hd_data[k] = qd[head];
    assign pend_src[k] = pend;
    always_ff @(posedge clk)
      if (push) begin
        qa[tail] <= src_waddr_i[k*ADDR_W +: ADDR_W];
        qd[tail] <= src_wdata_i[k*DATA_W +: DATA_W];
      end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        head <= '0;
        tail <= '0;
        cnt <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop) head <= head + PW'(1);
        if (push != pop) cnt <= push ? cnt + CW'(1) : cnt - CW'(1);
      end
    always_comb begin
      pend = '0;
      for (int e = 0; e < DEPTH; e++)
        if (e < int'(cnt)) pend[qa[head + PW'(e)]] = 1'b1;
    end
  end
  // first non-empty source strictly after last_grant, cyclically
  always_comb begin
    gnt_v = 1'b0;
    gnt = last_grant;
    cand = last_grant;
    for (int i = 1; i <= NSRC; i++) begin
      cand = GW'((int'(last_grant) + i) % NSRC);
      if (!gnt_v && ne[cand]) begin
        gnt_v = 1'b1;
        gnt = cand;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we_o <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
      last_grant <= GW'(NSRC - 1);
    end else begin
      we_o <= gnt_v;
      if (gnt_v) begin
        waddr_o <= hd_addr[gnt];
        wdata_o <= hd_data[gnt];
        last_grant <= gnt;
      end
    end
  always_comb begin
    pending_o = '0;
    for (int k = 0; k < NSRC; k++) pending_o = pending_o | pend_src[k];
    if (we_o) pending_o[waddr_o] = 1'b1;
    pending_o[0] = 1'b0;
  end
  assign idle_o = ~|ne && !we_o;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table-driven directed vectors for wb_arbiter plus a hand-written async reset sequence.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] src_valid_i;
  logic [3:0] src_ready_o;
  logic [19:0] src_waddr_i;
  logic [127:0] src_wdata_i;
  logic we_o;
  logic [4:0] waddr_o;
  logic [31:0] wdata_o;
  logic [31:0] pending_o;
  logic idle_o;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [3:0] v;
    logic [19:0] a;
    logic [127:0] d;
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic [3:0] rdy;
    logic [31:0] pend;
    logic idle;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  wb_arbiter dut (
    .clk(clk),
    .rst(rst),
    .src_valid_i(src_valid_i),
    .src_ready_o(src_ready_o),
    .src_waddr_i(src_waddr_i),
    .src_wdata_i(src_wdata_i),
    .we_o(we_o),
    .waddr_o(waddr_o),
    .wdata_o(wdata_o),
    .pending_o(pending_o),
    .idle_o(idle_o)
  );
  function automatic void add(logic [3:0] v, logic [19:0] a, logic [127:0] d, logic we, logic [4:0] wa,
                              logic [31:0] wd, logic [3:0] rdy, logic [31:0] pend, logic idle);
    vec_t t;
    t.v = v;
    t.a = a;
    t.d = d;
    t.we = we;
    t.wa = wa;
    t.wd = wd;
    t.rdy = rdy;
    t.pend = pend;
    t.idle = idle;
    tbl.push_back(t);
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    src_valid_i = '0;
    src_waddr_i = '0;
    src_wdata_i = '0;
    // four sources at once, then an immediate second round
    add(4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, 0, 4'hF, 32'h1E, 0);
    add(4'h0, 20'd0, 128'd0, 1, 1, 32'h11, 4'hF, 32'h1E, 0);
    add(4'h0, 20'd0, 128'd0, 1, 2, 32'h22, 4'hF, 32'h1C, 0);
    add(4'h0, 20'd0, 128'd0, 1, 3, 32'h33, 4'hF, 32'h18, 0);
    add(4'hF, {5'd8, 5'd7, 5'd6, 5'd5}, {32'h88, 32'h77, 32'h66, 32'h55}, 1, 4, 32'h44, 4'hF, 32'h1F0, 0);
    add(4'h0, 20'd0, 128'd0, 1, 5, 32'h55, 4'hF, 32'h1E0, 0);
    add(4'h0, 20'd0, 128'd0, 1, 6, 32'h66, 4'hF, 32'h1C0, 0);
    add(4'h0, 20'd0, 128'd0, 1, 7, 32'h77, 4'hF, 32'h180, 0);
    add(4'h0, 20'd0, 128'd0, 1, 8, 32'h88, 4'hF, 32'h100, 0);
    add(4'h0, 20'd0, 128'd0, 0, 8, 32'h88, 4'hF, 32'h0, 1);
    // single ALU write x5, two-edge latency
    add(4'h1, {15'd0, 5'd5}, {96'd0, 32'hDEADBEEF}, 0, 8, 32'h88, 4'hF, 32'h20, 0);
    add(4'h0, 20'd0, 128'd0, 1, 5, 32'hDEADBEEF, 4'hF, 32'h20, 0);
    add(4'h0, 20'd0, 128'd0, 0, 5, 32'hDEADBEEF, 4'hF, 32'h0, 1);
    // MUL fills while others hold the arbiter; ready drops then returns after a MUL pop
    add(4'h2, {10'd0, 5'd9, 5'd0}, {64'd0, 32'h91, 32'd0}, 0, 5, 32'hDEADBEEF, 4'hF, 32'h200, 0);
    add(4'hF, {5'd13, 5'd12, 5'd11, 5'd10}, {32'hD0, 32'hC0, 32'h92, 32'hA0}, 1, 9, 32'h91, 4'hF, 32'h3E00, 0);
    add(4'h2, {10'd0, 5'd14, 5'd0}, {64'd0, 32'h93, 32'd0}, 1, 12, 32'hC0, 4'hD, 32'h7C00, 0);
    add(4'h2, {10'd0, 5'd15, 5'd0}, {64'd0, 32'h94, 32'd0}, 1, 13, 32'hD0, 4'hD, 32'h6C00, 0);
    add(4'h2, {10'd0, 5'd15, 5'd0}, {64'd0, 32'h94, 32'd0}, 1, 10, 32'hA0, 4'hD, 32'h4C00, 0);
    add(4'h2, {10'd0, 5'd15, 5'd0}, {64'd0, 32'h94, 32'd0}, 1, 11, 32'h92, 4'hF, 32'h4800, 0);
    add(4'h2, {10'd0, 5'd15, 5'd0}, {64'd0, 32'h94, 32'd0}, 1, 14, 32'h93, 4'hF, 32'hC000, 0);
    add(4'h0, 20'd0, 128'd0, 1, 15, 32'h94, 4'hF, 32'h8000, 0);
    add(4'h0, 20'd0, 128'd0, 0, 15, 32'h94, 4'hF, 32'h0, 1);
    // LSU write to x0 is swallowed
    add(4'h8, 20'd0, {32'hBAD, 96'd0}, 0, 15, 32'h94, 4'hF, 32'h0, 1);
    add(4'h0, 20'd0, 128'd0, 0, 15, 32'h94, 4'hF, 32'h0, 1);
    // back-to-back DIV writes to x7
    add(4'h4, {5'd0, 5'd7, 10'd0}, {32'd0, 32'd1, 64'd0}, 0, 15, 32'h94, 4'hF, 32'h80, 0);
    add(4'h4, {5'd0, 5'd7, 10'd0}, {32'd0, 32'd2, 64'd0}, 1, 7, 32'd1, 4'hF, 32'h80, 0);
    add(4'h0, 20'd0, 128'd0, 1, 7, 32'd1 + 32'd1, 4'hF, 32'h80, 0);
    add(4'h0, 20'd0, 128'd0, 0, 7, 32'd2, 4'hF, 32'h0, 1);
    #1;
    chk("rst ready", src_ready_o, 4'h0);
    chk("rst we", we_o, 1'b0);
    chk("rst pending", pending_o, 32'h0);
    chk("rst idle", idle_o, 1'b1);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post-rst ready", src_ready_o, 4'hF);
    chk("post-rst waddr", waddr_o, 5'd0);
    chk("post-rst wdata", wdata_o, 32'd0);
    for (int i = 0; i < tbl.size(); i++) begin
      src_valid_i = tbl[i].v;
      src_waddr_i = tbl[i].a;
      src_wdata_i = tbl[i].d;
      step();
      chk($sformatf("v%0d we", i), we_o, tbl[i].we);
      chk($sformatf("v%0d waddr", i), waddr_o, tbl[i].wa);
      chk($sformatf("v%0d wdata", i), wdata_o, tbl[i].wd);
      chk($sformatf("v%0d ready", i), src_ready_o, tbl[i].rdy);
      chk($sformatf("v%0d pending", i), pending_o, tbl[i].pend);
      chk($sformatf("v%0d idle", i), idle_o, tbl[i].idle);
    end
    // async reset with three entries queued and a write on the output
    src_valid_i = 4'hF;
    src_waddr_i = {5'd19, 5'd18, 5'd17, 5'd16};
    src_wdata_i = {32'd4, 32'd3, 32'd2, 32'd1};
    step();
    src_valid_i = '0;
    step();
    chk("pre-ar we", we_o, 1'b1);
    chk("pre-ar waddr", waddr_o, 5'd19);
    chk("pre-ar pending", pending_o, 32'hF0000);
    #2 rst = 1'b1;
    #1;
    chk("ar we", we_o, 1'b0);
    chk("ar pending", pending_o, 32'h0);
    chk("ar ready", src_ready_o, 4'h0);
    chk("ar idle", idle_o, 1'b1);
    chk("ar waddr", waddr_o, 5'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("after-ar%0d we", i), we_o, 1'b0);
      chk($sformatf("after-ar%0d pending", i), pending_o, 32'h0);
      chk($sformatf("after-ar%0d idle", i), idle_o, 1'b1);
    end
    chk("after-ar ready", src_ready_o, 4'hF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
